// File: rtl/rv_pkg.sv
// Shared definitions for the integer pipeline: ALU op encodings and datapath
// width defaults used by the ID/EX stage and its forwarding muxes.
package rv_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding select for one source operand: EX/MEM beats MEM/WB, which beats
// the stored register-file value. Register x0 is never forwarded.
module fwd_mux
    import rv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rs_data,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [XLEN-1:0]       exm_data,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [XLEN-1:0]       mwb_data,
    output logic [XLEN-1:0]       fwd_data
);

    logic exm_hit;
    logic mwb_hit;

    always_comb begin
        exm_hit = exm_reg_write && (exm_rd == rs_addr) && (exm_rd != '0);
        mwb_hit = mwb_reg_write && (mwb_rd == rs_addr) && (mwb_rd != '0);
        fwd_data = rs_data;
        if (exm_hit) begin
            fwd_data = exm_data;
        end else if (mwb_hit) begin
            fwd_data = mwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush handling, operand forwarding and
// ALU operand selection feeding the execute stage directly.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [2:0]            id_funct3,
    input  logic                  id_op_extend,
    input  logic                  id_src1_pc,
    input  logic                  id_src2_imm,
    input  logic                  id_reg_write,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [XLEN-1:0]       exm_data,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [XLEN-1:0]       mwb_data,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_scr1,
    output logic [XLEN-1:0]       ex_scr2,
    output logic [2:0]            ex_op,
    output logic                  ex_op_extend,
    output logic [XLEN-1:0]       ex_rs2_fwd,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic [XLEN-1:0]       ex_pc
);

    logic                  valid_q,     valid_d;
    logic [XLEN-1:0]       pc_q,        pc_d;
    logic [XLEN-1:0]       rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q,  rs2_data_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [XLEN-1:0]       imm_q,       imm_d;
    logic [2:0]            funct3_q,    funct3_d;
    logic                  op_extend_q, op_extend_d;
    logic                  src1_pc_q,   src1_pc_d;
    logic                  src2_imm_q,  src2_imm_d;
    logic                  reg_write_q, reg_write_d;

    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr       (rs1_addr_q),
        .rs_data       (rs1_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_data      (exm_data),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_data      (mwb_data),
        .fwd_data      (fwd1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr       (rs2_addr_q),
        .rs_data       (rs2_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_data      (exm_data),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_data      (mwb_data),
        .fwd_data      (fwd2)
    );

    // While stalled, operand data re-latches the forwarded value so a MEM/WB
    // result that retires during the stall is not lost.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        imm_d       = imm_q;
        funct3_d    = funct3_q;
        op_extend_d = op_extend_q;
        src1_pc_d   = src1_pc_q;
        src2_imm_d  = src2_imm_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            rs1_addr_d  = '0;
            rs2_addr_d  = '0;
            rd_addr_d   = '0;
            imm_d       = '0;
            funct3_d    = ALU_ADD;
            op_extend_d = 1'b0;
            src1_pc_d   = 1'b0;
            src2_imm_d  = 1'b0;
            reg_write_d = 1'b0;
        end else if (stall) begin
            rs1_data_d = fwd1;
            rs2_data_d = fwd2;
        end else begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rd_addr_d   = id_rd_addr;
            imm_d       = id_imm;
            funct3_d    = id_funct3;
            op_extend_d = id_op_extend;
            src1_pc_d   = id_src1_pc;
            src2_imm_d  = id_src2_imm;
            reg_write_d = id_reg_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            imm_q       <= '0;
            funct3_q    <= '0;
            op_extend_q <= 1'b0;
            src1_pc_q   <= 1'b0;
            src2_imm_q  <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            imm_q       <= imm_d;
            funct3_q    <= funct3_d;
            op_extend_q <= op_extend_d;
            src1_pc_q   <= src1_pc_d;
            src2_imm_q  <= src2_imm_d;
            reg_write_q <= reg_write_d;
        end
    end

    always_comb begin
        ex_valid     = valid_q;
        ex_scr1      = src1_pc_q ? pc_q : fwd1;
        ex_scr2      = src2_imm_q ? imm_q : fwd2;
        ex_op        = funct3_q;
        ex_op_extend = op_extend_q;
        ex_rs2_fwd   = fwd2;
        ex_rd_addr   = rd_addr_q;
        ex_reg_write = reg_write_q && valid_q && (rd_addr_q != '0);
        ex_pc        = pc_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against an instruction-level model of the stage.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [31:0] id_imm;
    logic [2:0]  id_funct3;
    logic        id_op_extend;
    logic        id_src1_pc;
    logic        id_src2_imm;
    logic        id_reg_write;
    logic        stall;
    logic        flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic        ex_valid;
    logic [31:0] ex_scr1;
    logic [31:0] ex_scr2;
    logic [2:0]  ex_op;
    logic        ex_op_extend;
    logic [31:0] ex_rs2_fwd;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [31:0] ex_pc;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_imm        (id_imm),
        .id_funct3     (id_funct3),
        .id_op_extend  (id_op_extend),
        .id_src1_pc    (id_src1_pc),
        .id_src2_imm   (id_src2_imm),
        .id_reg_write  (id_reg_write),
        .stall         (stall),
        .flush         (flush),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_data      (exm_data),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_data      (mwb_data),
        .ex_valid      (ex_valid),
        .ex_scr1       (ex_scr1),
        .ex_scr2       (ex_scr2),
        .ex_op         (ex_op),
        .ex_op_extend  (ex_op_extend),
        .ex_rs2_fwd    (ex_rs2_fwd),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_pc         (ex_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The instruction currently held in execute, as the pipeline sees it.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  op;
        logic        op_ext;
        logic        use_pc;
        logic        use_imm;
        logic        writes_rd;
    } instr_t;

    instr_t m;

    // Latest in-flight producer of a register wins; x0 always reads its own value.
    function automatic logic [31:0] operand_value(input logic [4:0] r, input logic [31:0] rf_val);
        if (r == 5'd0) return rf_val;
        if (exm_reg_write && exm_rd == r) return exm_data;
        if (mwb_reg_write && mwb_rd == r) return mwb_data;
        return rf_val;
    endfunction

    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] v1;
        logic [31:0] v2;
        v1 = operand_value(m.rs1, m.rs1_val);
        v2 = operand_value(m.rs2, m.rs2_val);
        expectEq({tag, ".valid"},  32'(ex_valid),     32'(m.valid));
        expectEq({tag, ".scr1"},   ex_scr1,           m.use_pc ? m.pc : v1);
        expectEq({tag, ".scr2"},   ex_scr2,           m.use_imm ? m.imm : v2);
        expectEq({tag, ".op"},     32'(ex_op),        32'(m.op));
        expectEq({tag, ".opext"},  32'(ex_op_extend), 32'(m.op_ext));
        expectEq({tag, ".rs2fwd"}, ex_rs2_fwd,        v2);
        expectEq({tag, ".rd"},     32'(ex_rd_addr),   32'(m.rd));
        expectEq({tag, ".we"},     32'(ex_reg_write), 32'(m.valid && m.writes_rd && m.rd != 5'd0));
        expectEq({tag, ".pc"},     ex_pc,             m.pc);
    endtask

    // Advance one clock: decide what execute holds next, then let the edge happen.
    task automatic applyStimulus();
        instr_t nxt;
        nxt = m;
        if (flush) begin
            nxt = '0;
        end else if (stall) begin
            nxt.rs1_val = operand_value(m.rs1, m.rs1_val);
            nxt.rs2_val = operand_value(m.rs2, m.rs2_val);
        end else begin
            nxt = '{id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr,
                    id_rd_addr, id_imm, id_funct3, id_op_extend, id_src1_pc, id_src2_imm,
                    id_reg_write};
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic setInstr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                            input logic [31:0] imm, input logic [2:0] f3, input logic ext,
                            input logic s1pc, input logic s2imm, input logic we);
        id_valid = 1'b1; id_pc = pc;
        id_rs1_addr = rs1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_data = d2;
        id_rd_addr = rd; id_imm = imm; id_funct3 = f3; id_op_extend = ext;
        id_src1_pc = s1pc; id_src2_imm = s2imm; id_reg_write = we;
    endtask

    task automatic quietBypass();
        exm_reg_write = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_reg_write = 1'b0; mwb_rd = '0; mwb_data = '0;
    endtask

    initial begin
        m = '0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        setInstr('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
        quietBypass();
        #12;
        checkOutput("por");
        rst = 1'b0;

        // Asynchronous reset while a valid ADD is held
        setInstr(32'h40, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("add_loaded");
        #2 rst = 1'b1;
        #1;
        m = '0;
        checkOutput("async_rst");
        expectEq("async_rst.valid0", 32'(ex_valid), 32'd0);
        rst = 1'b0;

        // addi x?, x?, 7 with rs1 = 5
        setInstr(32'h44, 5'd6, 32'd5, 5'd0, 32'd0, 5'd7, 32'd7, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("addi");
        expectEq("addi.scr1", ex_scr1, 32'd5);
        expectEq("addi.scr2", ex_scr2, 32'd7);

        // Forwarding priority on rs1 = x3
        setInstr(32'h48, 5'd3, 32'h33, 5'd0, 32'd0, 5'd8, 32'd0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus();
        exm_reg_write = 1'b1; exm_rd = 5'd3; exm_data = 32'hAA;
        mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_data = 32'hBB;
        #1;
        checkOutput("fwd_both");
        expectEq("fwd_both.scr1", ex_scr1, 32'hAA);
        exm_rd = 5'd0;
        #1;
        checkOutput("fwd_mwb");
        expectEq("fwd_mwb.scr1", ex_scr1, 32'hBB);

        // x0 is never forwarded
        setInstr(32'h4C, 5'd0, 32'h55, 5'd0, 32'h66, 5'd9, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        mwb_rd = 5'd0; exm_rd = 5'd0;
        applyStimulus();
        checkOutput("x0");
        expectEq("x0.scr1", ex_scr1, 32'h55);

        // Two-cycle stall while a MEM/WB value for rs2 retires
        quietBypass();
        setInstr(32'h50, 5'd1, 32'h1, 5'd4, 32'h0, 5'd10, 32'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        setInstr(32'h54, 5'd2, 32'h9, 5'd2, 32'h9, 5'd11, 32'h9, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        mwb_reg_write = 1'b1; mwb_rd = 5'd4; mwb_data = 32'h1234;
        applyStimulus();
        checkOutput("stall1");
        mwb_rd = 5'd9; mwb_data = 32'hDEAD;
        applyStimulus();
        checkOutput("stall2");
        stall = 1'b0;
        #1;
        checkOutput("stall_rel");
        expectEq("stall_rel.rs2fwd", ex_rs2_fwd, 32'h1234);
        expectEq("stall_rel.op", 32'(ex_op), 32'(3'b100));
        expectEq("stall_rel.rd", 32'(ex_rd_addr), 32'd10);

        // Flush overrides stall while holding a SUB
        quietBypass();
        setInstr(32'h58, 5'd1, 32'h10, 5'd2, 32'h3, 5'd12, 32'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("sub");
        stall = 1'b1; flush = 1'b1;
        applyStimulus();
        stall = 1'b0; flush = 1'b0;
        checkOutput("flush");
        expectEq("flush.we", 32'(ex_reg_write), 32'd0);
        expectEq("flush.opext", 32'(ex_op_extend), 32'd0);

        // auipc-style operands, then the same with rd = x0
        setInstr(32'h100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd13, 32'h2000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("auipc");
        expectEq("auipc.scr1", ex_scr1, 32'h100);
        expectEq("auipc.scr2", ex_scr2, 32'h2000);
        expectEq("auipc.we", 32'(ex_reg_write), 32'd1);
        id_rd_addr = 5'd0;
        applyStimulus();
        checkOutput("auipc_x0");
        expectEq("auipc_x0.we", 32'(ex_reg_write), 32'd0);

        // Random traffic with a small register window so hazards are common
        for (int i = 0; i < 400; i++) begin
            id_valid      = 1'($urandom_range(0, 3) != 0);
            id_pc         = $urandom;
            id_rs1_addr   = 5'($urandom_range(0, 7));
            id_rs2_addr   = 5'($urandom_range(0, 7));
            id_rd_addr    = 5'($urandom_range(0, 7));
            id_rs1_data   = $urandom;
            id_rs2_data   = $urandom;
            id_imm        = $urandom;
            id_funct3     = 3'($urandom);
            id_op_extend  = 1'($urandom);
            id_src1_pc    = 1'($urandom);
            id_src2_imm   = 1'($urandom);
            id_reg_write  = 1'($urandom);
            stall         = 1'($urandom_range(0, 3) == 0);
            flush         = 1'($urandom_range(0, 9) == 0);
            exm_reg_write = 1'($urandom);
            exm_rd        = 5'($urandom_range(0, 7));
            exm_data      = $urandom;
            mwb_reg_write = 1'($urandom);
            mwb_rd        = 5'($urandom_range(0, 7));
            mwb_data      = $urandom;
            applyStimulus();
            checkOutput($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
